tick_sequencer: RTL and testbench
=================================

TICK_SEQUENCER -- requirements
Module: tick_sequencer

Interface
REQ-001 Parameter CNT_W, default 28: divider counter width.
REQ-002 Parameter R1, default 49_999_999: reload value for rate_sel 2'b01.
REQ-003 Parameter R2, default 99_999_999: reload value for rate_sel 2'b10.
REQ-004 Parameter R3, default 199_999_999: reload value for rate_sel 2'b11; rate_sel 2'b00 SHALL use reload 0.
REQ-005 Clock  in  1  sole clock; one clock, all state on posedge.
REQ-006 reset  in  1  reset is asynchronous and active-high.
REQ-007 rate_sel  in  2  tick rate selector.
REQ-008 burst_len  in  8  ticks per burst; 0 = continuous.
REQ-009 start  in  1  start (from IDLE) or resume (from HOLD).
REQ-010 stop  in  1  pause (RUN/STEP) or abort (HOLD).
REQ-011 step  in  1  single-interval request, honoured in HOLD only.
REQ-012 tick  out  1  one-cycle enable for a downstream display counter.
REQ-013 busy  out  1  high whenever state != IDLE.
REQ-014 done  out  1  one-cycle pulse on burst completion.
REQ-015 tick_count  out  8  ticks issued since last start.
REQ-016 state  out  2  IDLE=00, RUN=01, STEP=10, HOLD=11.

Function
REQ-017 Control input priority SHALL be stop > start > step, all sampled on the rising edge of Clock.
REQ-018 In IDLE, start SHALL go to RUN, latch the reload value for rate_sel and latch burst_len, clear tick_count, and load the counter with the reload value.
REQ-019 rate_sel and burst_len changes after start SHALL be ignored until the next start from IDLE.
REQ-020 In RUN/STEP, the counter SHALL decrement by 1 per cycle while nonzero; when it is 0, tick SHALL be high that cycle and the counter SHALL reload.
REQ-021 tick SHALL be decoded from registered state only: tick = (state is RUN or STEP) and counter == 0; tick period = reload+1 cycles; first tick = reload+1 cycles after the start edge.
REQ-022 Each tick SHALL increment tick_count modulo 256; in continuous mode 255 wraps to 0 with no other effect.
REQ-023 If latched burst_len != 0 and a tick brings tick_count to burst_len, next state SHALL be IDLE and done SHALL pulse for one cycle on the following cycle; tick_count holds its final value.
REQ-024 stop in RUN SHALL go to HOLD with the counter frozen, unchanged on that edge, unless the counter is 0: in that case the tick still fires, is counted, and the counter reloads.
REQ-025 In HOLD the counter and tick_count SHALL hold; start SHALL return to RUN without reloading; stop SHALL go to IDLE (abort, no done).
REQ-026 step in HOLD SHALL go to STEP; the counter continues from its frozen value; after one tick, STEP SHALL return to HOLD, or go to IDLE with done if REQ-023 applies.
REQ-027 stop in STEP SHALL go to HOLD with the counter frozen; start in STEP SHALL be ignored.
REQ-028 start in RUN, step outside HOLD, and stop in IDLE SHALL be ignored.
REQ-029 With reload 0, tick SHALL be high every cycle in RUN.

Reset
REQ-030 reset high SHALL immediately force state=IDLE, counter=0, tick_count=0, done=0, tick=0, busy=0, latched reload=0 and latched burst_len=0, independent of Clock.
REQ-031 Deassertion of reset SHALL leave the block in IDLE awaiting start; no done pulse is caused by reset.

Verification
REQ-032 R1=3, rate_sel=01, burst_len=4, start at cycle 0 -> tick at cycles 4, 8, 12, 16; busy low and done high at cycle 17; tick_count=4.
REQ-033 rate_sel=00, burst_len=0, start -> tick every cycle from cycle 1; tick_count 255->0 after 256 ticks; busy stays 1; done never fires.
REQ-034 R1=3 run, stop at cycle 6 (counter=2) -> HOLD from cycle 7, no ticks; start at cycle 10 -> RUN at 11, tick at 13.
REQ-035 In HOLD with counter=2, step -> STEP, one tick 3 cycles later, then HOLD with counter=R1; a later step gives the next tick R1+1 cycles after entry.
REQ-036 Async reset pulse mid-RUN, between clock edges -> state=00, tick_count=0, busy=0 before the next edge; no done.
REQ-037 start and stop together in IDLE -> stays IDLE; start and stop together in HOLD -> IDLE.

Source files
------------

// File: rtl/tick_sequencer.sv
// Programmable tick generator: divides Clock by a latched reload value and issues
// tick enables in continuous, burst or single-step mode, with pause/resume/abort.
module tick_sequencer #(
  parameter int unsigned CNT_W = 28,
  parameter int unsigned R1    = 49_999_999,
  parameter int unsigned R2    = 99_999_999,
  parameter int unsigned R3    = 199_999_999
) (
  input  logic             Clock,
  input  logic             reset,
  input  logic [1:0]       rate_sel,
  input  logic [7:0]       burst_len,
  input  logic             start,
  input  logic             stop,
  input  logic             step,
  output logic             tick,
  output logic             busy,
  output logic             done,
  output logic [7:0]       tick_count,
  output logic [1:0]       state
);

  localparam logic [1:0] S_IDLE = 2'b00;
  localparam logic [1:0] S_RUN  = 2'b01;
  localparam logic [1:0] S_STEP = 2'b10;
  localparam logic [1:0] S_HOLD = 2'b11;

  logic [CNT_W-1:0] counter;
  logic [CNT_W-1:0] reload_q;
  logic [7:0]       burst_q;

  logic [1:0]       state_d;
  logic [CNT_W-1:0] counter_d;
  logic [CNT_W-1:0] reload_d;
  logic [7:0]       burst_d;
  logic [7:0]       tick_count_d;
  logic             done_d;
  logic [CNT_W-1:0] sel_reload;
  logic [7:0]       tick_count_inc;

  // Reload value selected by rate_sel; only sampled on a start from IDLE.
  always_comb begin
    sel_reload = '0;
    case (rate_sel)
      2'b01:   sel_reload = CNT_W'(R1);
      2'b10:   sel_reload = CNT_W'(R2);
      2'b11:   sel_reload = CNT_W'(R3);
      default: sel_reload = '0;
    endcase
  end

  assign tick           = ((state == S_RUN) || (state == S_STEP)) && (counter == '0);
  assign busy           = (state != S_IDLE);
  assign tick_count_inc = tick_count + 8'd1;

  // Next-state logic; priority stop > start > step. A due tick always fires,
  // even when stop arrives on the same edge, and burst completion wins over stop.
  always_comb begin
    state_d      = state;
    counter_d    = counter;
    reload_d     = reload_q;
    burst_d      = burst_q;
    tick_count_d = tick_count;
    done_d       = 1'b0;
    case (state)
      S_IDLE: begin
        if (!stop && start) begin
          state_d      = S_RUN;
          reload_d     = sel_reload;
          burst_d      = burst_len;
          tick_count_d = 8'd0;
          counter_d    = sel_reload;
        end
      end
      S_RUN, S_STEP: begin
        if (tick) begin
          counter_d    = reload_q;
          tick_count_d = tick_count_inc;
          if ((burst_q != 8'd0) && (tick_count_inc == burst_q)) begin
            state_d = S_IDLE;
            done_d  = 1'b1;
          end else if (stop || (state == S_STEP)) begin
            state_d = S_HOLD;
          end
        end else if (stop) begin
          state_d = S_HOLD;
        end else begin
          counter_d = counter - CNT_W'(1);
        end
      end
      S_HOLD: begin
        if (stop) begin
          state_d = S_IDLE;
        end else if (start) begin
          state_d = S_RUN;
        end else if (step) begin
          state_d = S_STEP;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge Clock or posedge reset) begin
    if (reset) begin
      state      <= S_IDLE;
      counter    <= '0;
      reload_q   <= '0;
      burst_q    <= 8'd0;
      tick_count <= 8'd0;
      done       <= 1'b0;
    end else begin
      state      <= state_d;
      counter    <= counter_d;
      reload_q   <= reload_d;
      burst_q    <= burst_d;
      tick_count <= tick_count_d;
      done       <= done_d;
    end
  end

endmodule

// File: tb/tb_tick_sequencer.sv
// Scoreboard bench for tick_sequencer: the driver queues expected tick/done cycles,
// a monitor pops and compares them whenever the DUT raises tick or done.
module tb_tick_sequencer;

  logic       Clock = 1'b0;
  logic       reset;
  logic [1:0] rate_sel;
  logic [7:0] burst_len;
  logic       start, stop, step;
  logic       tick, busy, done;
  logic [7:0] tick_count;
  logic [1:0] state;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int exp_tick[$];
  int exp_done[$];

  tick_sequencer #(.CNT_W(28), .R1(3), .R2(5), .R3(7)) dut (
    .Clock(Clock), .reset(reset), .rate_sel(rate_sel), .burst_len(burst_len),
    .start(start), .stop(stop), .step(step), .tick(tick), .busy(busy),
    .done(done), .tick_count(tick_count), .state(state)
  );

  always #5 Clock = ~Clock;
  always @(posedge Clock) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s cycle=%0d actual=%0d required=%0d", name, cyc, act, req);
    end
  endtask

  // Monitor: every tick/done the DUT presents must match the head of its queue.
  always @(negedge Clock) begin
    int e;
    if (!reset) begin
      if (tick) begin
        checks++;
        if (exp_tick.size() == 0) begin
          failures++;
          $display("FAIL tick_unexpected cycle=%0d actual=1 required=0", cyc);
        end else begin
          e = exp_tick.pop_front();
          if (e != cyc) begin
            failures++;
            $display("FAIL tick_cycle actual=%0d required=%0d", cyc, e);
          end
        end
      end else if (exp_tick.size() > 0 && exp_tick[0] <= cyc) begin
        e = exp_tick.pop_front();
        checks++;
        failures++;
        $display("FAIL tick_missing actual=none required=%0d", e);
      end
      if (done) begin
        checks++;
        if (exp_done.size() == 0) begin
          failures++;
          $display("FAIL done_unexpected cycle=%0d actual=1 required=0", cyc);
        end else begin
          e = exp_done.pop_front();
          if (e != cyc) begin
            failures++;
            $display("FAIL done_cycle actual=%0d required=%0d", cyc, e);
          end
        end
      end else if (exp_done.size() > 0 && exp_done[0] <= cyc) begin
        e = exp_done.pop_front();
        checks++;
        failures++;
        $display("FAIL done_missing actual=none required=%0d", e);
      end
    end
  end

  task automatic wait_until(input int c);
    while (cyc < c) @(negedge Clock);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog cycle=%0d actual=timeout required=finish", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    int c0;
    reset = 1'b1; rate_sel = 2'b00; burst_len = 8'd0;
    start = 1'b0; stop = 1'b0; step = 1'b0;
    repeat (3) @(negedge Clock);
    chk("reset_state", int'(state), 0);
    chk("reset_busy", int'(busy), 0);
    chk("reset_count", int'(tick_count), 0);
    chk("reset_tick_done", int'({tick, done}), 0);
    reset = 1'b0;
    repeat (2) @(negedge Clock);

    // Burst of 4 at reload 3; later input changes must be ignored.
    c0 = cyc;
    rate_sel = 2'b01; burst_len = 8'd4; start = 1'b1;
    exp_tick.push_back(c0 + 4);  exp_tick.push_back(c0 + 8);
    exp_tick.push_back(c0 + 12); exp_tick.push_back(c0 + 16);
    exp_done.push_back(c0 + 17);
    @(negedge Clock);
    start = 1'b0; rate_sel = 2'b11; burst_len = 8'd9;
    wait_until(c0 + 16);
    chk("burst_busy_c16", int'(busy), 1);
    wait_until(c0 + 17);
    chk("burst_busy_c17", int'(busy), 0);
    chk("burst_state_c17", int'(state), 0);
    chk("burst_count", int'(tick_count), 4);
    repeat (3) @(negedge Clock);

    // start+stop together in IDLE stays IDLE.
    start = 1'b1; stop = 1'b1;
    @(negedge Clock);
    start = 1'b0; stop = 1'b0;
    chk("idle_start_stop", int'(state), 0);
    @(negedge Clock);

    // Reload 0, continuous: tick every cycle, count wraps after 256 ticks.
    c0 = cyc;
    rate_sel = 2'b00; burst_len = 8'd0; start = 1'b1;
    for (int i = 1; i <= 257; i++) exp_tick.push_back(c0 + i);
    @(negedge Clock);
    start = 1'b0;
    wait_until(c0 + 256);
    chk("cont_count_255", int'(tick_count), 255);
    wait_until(c0 + 257);
    chk("cont_count_wrap", int'(tick_count), 0);
    chk("cont_busy", int'(busy), 1);
    stop = 1'b1;                     // counter is 0: tick still fires, then HOLD
    @(negedge Clock);
    stop = 1'b0;
    chk("cont_hold_state", int'(state), 3);
    chk("cont_hold_count", int'(tick_count), 1);
    stop = 1'b1;                     // abort from HOLD, no done
    @(negedge Clock);
    stop = 1'b0;
    chk("abort_state", int'(state), 0);
    repeat (2) @(negedge Clock);

    // Pause / resume / single step at reload 3.
    c0 = cyc;
    rate_sel = 2'b01; burst_len = 8'd0; start = 1'b1;
    exp_tick.push_back(c0 + 4);  exp_tick.push_back(c0 + 13);
    exp_tick.push_back(c0 + 20); exp_tick.push_back(c0 + 26);
    @(negedge Clock);
    start = 1'b0;
    wait_until(c0 + 6);
    stop = 1'b1;
    @(negedge Clock);
    stop = 1'b0;
    chk("pause_state", int'(state), 3);
    wait_until(c0 + 10);
    chk("pause_count", int'(tick_count), 1);
    start = 1'b1;
    @(negedge Clock);
    start = 1'b0;
    chk("resume_state", int'(state), 1);
    wait_until(c0 + 15);
    stop = 1'b1;
    @(negedge Clock);
    stop = 1'b0;
    wait_until(c0 + 17);
    step = 1'b1;
    @(negedge Clock);
    step = 1'b0;
    chk("step_state", int'(state), 2);
    wait_until(c0 + 21);
    chk("step_back_hold", int'(state), 3);
    chk("step_count", int'(tick_count), 3);
    wait_until(c0 + 22);
    step = 1'b1;
    @(negedge Clock);
    step = 1'b0; start = 1'b1;       // start in STEP is ignored
    @(negedge Clock);
    start = 1'b0;
    chk("step_ignore_start", int'(state), 2);
    wait_until(c0 + 27);
    chk("step2_hold", int'(state), 3);
    chk("step2_count", int'(tick_count), 4);
    wait_until(c0 + 28);
    start = 1'b1; stop = 1'b1;
    @(negedge Clock);
    start = 1'b0; stop = 1'b0;
    chk("hold_start_stop", int'(state), 0);
    repeat (2) @(negedge Clock);

    // Reload 5 single-tick burst.
    c0 = cyc;
    rate_sel = 2'b10; burst_len = 8'd1; start = 1'b1;
    exp_tick.push_back(c0 + 6);
    exp_done.push_back(c0 + 7);
    @(negedge Clock);
    start = 1'b0;
    wait_until(c0 + 7);
    chk("r2_state", int'(state), 0);
    chk("r2_count", int'(tick_count), 1);
    repeat (2) @(negedge Clock);

    // Asynchronous reset between clock edges mid-RUN.
    c0 = cyc;
    rate_sel = 2'b11; burst_len = 8'd0; start = 1'b1;
    exp_tick.push_back(c0 + 8);
    @(negedge Clock);
    start = 1'b0;
    wait_until(c0 + 10);
    chk("pre_reset_count", int'(tick_count), 1);
    #1 reset = 1'b1;
    #1;
    chk("async_state", int'(state), 0);
    chk("async_count", int'(tick_count), 0);
    chk("async_busy", int'(busy), 0);
    #1 reset = 1'b0;
    repeat (4) @(negedge Clock);
    chk("post_reset_state", int'(state), 0);

    chk("tick_queue_empty", exp_tick.size(), 0);
    chk("done_queue_empty", exp_done.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
